// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage -- decode stage of the 5-stage MIPS pipeline.
//
// Holds the IF/ID pipeline register and the 32x32 general register file,
// selects forwarded operands, computes the three redirect targets and
// resolves beq/bne/j/jal/jr in D. Delay-slot architecture: nothing is
// flushed; the fetch unit simply follows NPC_ctrl.
//
// Ports
//   Clk         in   system clock, rising-edge active
//   Reset       in   synchronous, active-low reset
//   En          in   IF/ID load enable (0 = stall, hold D contents)
//   PC4_F       in   PC+4 from fetch
//   Ins_F       in   instruction from fetch
//   RegWrite_W  in   writeback write enable
//   A3_W        in   writeback destination register
//   WD_W        in   writeback data
//   Fwd_RS_sel  in   rs source: 00 RF, 01 Fwd_M, 10 Fwd_E, 11 RF
//   Fwd_RT_sel  in   rt source, same encoding
//   Fwd_E       in   forwarded value from E
//   Fwd_M       in   forwarded value from M
//   Ins_D       out  registered instruction
//   PC4_D       out  registered PC+4
//   RD1 / RD2   out  forwarded rs / rt values
//   BR          out  branch target
//   JR          out  jr target
//   J_JAL       out  j/jal target
//   NPC_ctrl    out  next-PC select: 00 PC4, 01 BR, 10 JR, 11 J_JAL
//
// Flow control: there is no valid/ready handshake. En is a plain load
// enable driven by the hazard unit; while it is low D holds its contents
// and every output is recomputed from the held instruction, so targets
// and NPC_ctrl stay stable for the whole stall.
// ---------------------------------------------------------------------------
module id_stage #(
  parameter logic [31:0] RESET_PC4 = 32'h0000_3004,
  parameter int          REG_NUM   = 32
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        En,
  input  logic [31:0] PC4_F,
  input  logic [31:0] Ins_F,
  input  logic        RegWrite_W,
  input  logic [4:0]  A3_W,
  input  logic [31:0] WD_W,
  input  logic [1:0]  Fwd_RS_sel,
  input  logic [1:0]  Fwd_RT_sel,
  input  logic [31:0] Fwd_E,
  input  logic [31:0] Fwd_M,
  output logic [31:0] Ins_D,
  output logic [31:0] PC4_D,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic [31:0] BR,
  output logic [31:0] JR,
  output logic [31:0] J_JAL,
  output logic [1:0]  NPC_ctrl
);

  // -------------------------------------------------------------------------
  // Encodings
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    NPC_PC4  = 2'b00,
    NPC_BR   = 2'b01,
    NPC_JR   = 2'b10,
    NPC_JJAL = 2'b11
  } npc_sel_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_M   = 2'b01,
    FWD_E   = 2'b10,
    FWD_RF2 = 2'b11
  } fwd_sel_e;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] FN_JR      = 6'b001000;

  // -------------------------------------------------------------------------
  // IF/ID pipeline register
  // -------------------------------------------------------------------------
  logic [31:0] ins_q, ins_d;
  logic [31:0] pc4_q, pc4_d;

  always_comb begin
    ins_d = ins_q;
    pc4_d = pc4_q;
    if (En) begin
      ins_d = Ins_F;
      pc4_d = PC4_F;
    end
  end

  // Reset wins over En: a reset edge always leaves a nop in D.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      ins_q <= '0;
      pc4_q <= RESET_PC4;
    end else begin
      ins_q <= ins_d;
      pc4_q <= pc4_d;
    end
  end

  assign Ins_D = ins_q;
  assign PC4_D = pc4_q;

  // -------------------------------------------------------------------------
  // Instruction fields
  // -------------------------------------------------------------------------
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [15:0] imm;
  logic [25:0] index;

  assign op    = ins_q[31:26];
  assign rs    = ins_q[25:21];
  assign rt    = ins_q[20:16];
  assign imm   = ins_q[15:0];
  assign funct = ins_q[5:0];
  assign index = ins_q[25:0];

  // -------------------------------------------------------------------------
  // Register file
  // -------------------------------------------------------------------------
  logic [31:0] rf_q [REG_NUM];
  logic        rf_we;

  assign rf_we = RegWrite_W && (A3_W != 5'd0);

  // Entry 0 is cleared by reset and never written, but the read path
  // forces $0 to zero anyway so it does not depend on that.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int i = 0; i < REG_NUM; i++) begin
        rf_q[i] <= '0;
      end
    end else if (rf_we) begin
      rf_q[A3_W] <= WD_W;
    end
  end

  // Combinational read with write-through: a register being written by W
  // in this cycle is seen by D in the same cycle, so W never needs to be
  // a forwarding source.
  logic [31:0] rf_rd1, rf_rd2;

  always_comb begin
    rf_rd1 = '0;
    if (rs != 5'd0) begin
      if (rf_we && (A3_W == rs)) rf_rd1 = WD_W;
      else                       rf_rd1 = rf_q[rs];
    end
  end

  always_comb begin
    rf_rd2 = '0;
    if (rt != 5'd0) begin
      if (rf_we && (A3_W == rt)) rf_rd2 = WD_W;
      else                       rf_rd2 = rf_q[rt];
    end
  end

  // -------------------------------------------------------------------------
  // Operand forwarding
  // -------------------------------------------------------------------------
  fwd_sel_e rs_sel, rt_sel;

  assign rs_sel = fwd_sel_e'(Fwd_RS_sel);
  assign rt_sel = fwd_sel_e'(Fwd_RT_sel);

  always_comb begin
    RD1 = rf_rd1;
    case (rs_sel)
      FWD_M:   RD1 = Fwd_M;
      FWD_E:   RD1 = Fwd_E;
      default: RD1 = rf_rd1;
    endcase
  end

  always_comb begin
    RD2 = rf_rd2;
    case (rt_sel)
      FWD_M:   RD2 = Fwd_M;
      FWD_E:   RD2 = Fwd_E;
      default: RD2 = rf_rd2;
    endcase
  end

  // -------------------------------------------------------------------------
  // Redirect targets
  // -------------------------------------------------------------------------
  logic [31:0] br_offset;

  // Word offset, sign-extended and scaled by 4; the add wraps at 32 bits.
  assign br_offset = {{14{imm[15]}}, imm, 2'b00};
  assign BR        = pc4_q + br_offset;
  assign J_JAL     = {pc4_q[31:28], index, 2'b00};
  assign JR        = RD1;

  // -------------------------------------------------------------------------
  // Next-PC decision (compares the forwarded operands, never raw RF)
  // -------------------------------------------------------------------------
  npc_sel_e npc_sel;
  logic     ops_equal;

  assign ops_equal = (RD1 == RD2);

  always_comb begin
    npc_sel = NPC_PC4;
    case (op)
      OP_BEQ:     npc_sel = ops_equal ? NPC_BR : NPC_PC4;
      OP_BNE:     npc_sel = ops_equal ? NPC_PC4 : NPC_BR;
      OP_J,
      OP_JAL:     npc_sel = NPC_JJAL;
      OP_SPECIAL: npc_sel = (funct == FN_JR) ? NPC_JR : NPC_PC4;
      default:    npc_sel = NPC_PC4;
    endcase
  end

  assign NPC_ctrl = npc_sel;

endmodule

// File: tb/tb_id_stage.sv
// ---------------------------------------------------------------------------
// tb_id_stage -- self-checking bench for id_stage.
// A reference model of D (instruction, PC+4, architectural registers) is
// updated on every rising edge from the inputs; a compare process checks
// every DUT output against it on each falling edge. Directed sequences add
// hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_id_stage;

  localparam logic [31:0] RESET_PC4 = 32'h0000_3004;

  // ---------------------------------------------------------------- clock/reset
  logic        Clk;
  logic        Reset;
  logic        En;
  logic [31:0] PC4_F, Ins_F;
  logic        RegWrite_W;
  logic [4:0]  A3_W;
  logic [31:0] WD_W;
  logic [1:0]  Fwd_RS_sel, Fwd_RT_sel;
  logic [31:0] Fwd_E, Fwd_M;
  logic [31:0] Ins_D, PC4_D, RD1, RD2, BR, JR, J_JAL;
  logic [1:0]  NPC_ctrl;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  id_stage #(.RESET_PC4(RESET_PC4), .REG_NUM(32)) dut (
    .Clk(Clk), .Reset(Reset), .En(En), .PC4_F(PC4_F), .Ins_F(Ins_F),
    .RegWrite_W(RegWrite_W), .A3_W(A3_W), .WD_W(WD_W),
    .Fwd_RS_sel(Fwd_RS_sel), .Fwd_RT_sel(Fwd_RT_sel),
    .Fwd_E(Fwd_E), .Fwd_M(Fwd_M),
    .Ins_D(Ins_D), .PC4_D(PC4_D), .RD1(RD1), .RD2(RD2),
    .BR(BR), .JR(JR), .J_JAL(J_JAL), .NPC_ctrl(NPC_ctrl)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  logic [31:0] m_ins, m_pc4;
  logic [31:0] m_rf [32];
  logic        m_valid = 1'b0;

  always @(posedge Clk) begin
    if (!Reset) begin
      m_ins   <= 32'h0;
      m_pc4   <= RESET_PC4;
      for (int i = 0; i < 32; i++) m_rf[i] <= 32'h0;
      m_valid <= 1'b1;
    end else begin
      if (En) begin
        m_ins <= Ins_F;
        m_pc4 <= PC4_F;
      end
      if (RegWrite_W && A3_W != 0) m_rf[A3_W] <= WD_W;
    end
  end

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (RegWrite_W && A3_W == a) return WD_W;
    return m_rf[a];
  endfunction

  function automatic logic [31:0] m_pick(input logic [1:0] sel, input logic [31:0] rf_val);
    if (sel == 2'd1) return Fwd_M;
    if (sel == 2'd2) return Fwd_E;
    return rf_val;
  endfunction

  // ---------------------------------------------------------------- scoreboard
  localparam int VW = 32 * 7 + 2;
  logic [VW-1:0] exp_q[$];

  always @(negedge Clk) begin
    if (m_valid) begin
      logic [31:0] e_rd1, e_rd2, e_br, e_jj;
      logic [1:0]  e_npc;
      logic [VW-1:0] v;
      int          off;
      e_rd1 = m_pick(Fwd_RS_sel, m_read(m_ins[25:21]));
      e_rd2 = m_pick(Fwd_RT_sel, m_read(m_ins[20:16]));
      off   = int'($signed(m_ins[15:0])) * 4;
      e_br  = m_pc4 + 32'(off);
      e_jj  = (m_pc4 & 32'hF000_0000) | (32'(m_ins[25:0]) * 4);
      case (m_ins[31:26])
        6'd4:       e_npc = (e_rd1 == e_rd2) ? 2'd1 : 2'd0;
        6'd5:       e_npc = (e_rd1 != e_rd2) ? 2'd1 : 2'd0;
        6'd2, 6'd3: e_npc = 2'd3;
        6'd0:       e_npc = (m_ins[5:0] == 6'd8) ? 2'd2 : 2'd0;
        default:    e_npc = 2'd0;
      endcase
      exp_q.push_back({m_ins, m_pc4, e_rd1, e_rd2, e_br, e_rd1, e_jj, e_npc});
      v = exp_q.pop_front();
      check32("cyc_ins_d", Ins_D, v[225:194]);
      check32("cyc_pc4_d", PC4_D, v[193:162]);
      check32("cyc_rd1",   RD1,   v[161:130]);
      check32("cyc_rd2",   RD2,   v[129:98]);
      check32("cyc_br",    BR,    v[97:66]);
      check32("cyc_jr",    JR,    v[65:34]);
      check32("cyc_j_jal", J_JAL, v[33:2]);
      check32("cyc_npc",   32'(NPC_ctrl), 32'(v[1:0]));
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load_ins(input logic [31:0] pc4, input logic [31:0] ins);
    PC4_F = pc4;
    Ins_F = ins;
    En    = 1'b1;
    tick();
    En    = 1'b0;
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    RegWrite_W = 1'b1;
    A3_W       = a;
    WD_W       = d;
    tick();
    RegWrite_W = 1'b0;
    A3_W       = 5'd0;
    WD_W       = 32'h0;
    #1;
  endtask

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // R-type "add $0, rs, rt": reads both registers without redirecting.
  function automatic logic [31:0] mk_add(input logic [4:0] rs, input logic [4:0] rt);
    return {6'd0, rs, rt, 5'd0, 5'd0, 6'h20};
  endfunction

  // ---------------------------------------------------------------- stimulus
  initial begin
    Reset = 1'b0; En = 1'b0; PC4_F = 32'h0; Ins_F = 32'h0;
    RegWrite_W = 1'b0; A3_W = 5'd0; WD_W = 32'h0;
    Fwd_RS_sel = 2'b00; Fwd_RT_sel = 2'b00; Fwd_E = 32'h0; Fwd_M = 32'h0;

    // Reset for two cycles.
    tick(); tick();
    Reset = 1'b1;
    #1;
    check32("rst_ins_d", Ins_D, 32'h0);
    check32("rst_pc4_d", PC4_D, 32'h0000_3004);
    check32("rst_npc",   32'(NPC_ctrl), 32'd0);
    for (int i = 1; i < 32; i++) begin
      load_ins(32'h3008, mk_add(5'(i), 5'(i)));
      check32("rst_reg_rd1", RD1, 32'h0);
      check32("rst_reg_rd2", RD2, 32'h0);
    end

    // Write-through bypass on $5, then $0 stays zero.
    load_ins(32'h3010, mk_add(5'd5, 5'd0));
    RegWrite_W = 1'b1; A3_W = 5'd5; WD_W = 32'hDEAD_BEEF;
    #1;
    check32("bypass_rd1", RD1, 32'hDEAD_BEEF);
    tick();
    RegWrite_W = 1'b0; A3_W = 5'd0; WD_W = 32'h0;
    #1;
    check32("stored_rd1", RD1, 32'hDEAD_BEEF);
    load_ins(32'h3014, mk_add(5'd0, 5'd0));
    RegWrite_W = 1'b1; A3_W = 5'd0; WD_W = 32'h1234;
    #1;
    check32("zero_bypass", RD1, 32'h0);
    tick();
    RegWrite_W = 1'b0; WD_W = 32'h0;
    #1;
    check32("zero_stored", RD1, 32'h0);

    // beq $1,$2,-1 taken, then not taken once $2 changes.
    write_reg(5'd1, 32'd7);
    write_reg(5'd2, 32'd7);
    load_ins(32'h3010, mk_i(6'b000100, 5'd1, 5'd2, 16'hFFFF));
    check32("beq_taken_npc", 32'(NPC_ctrl), 32'd1);
    check32("beq_br",        BR, 32'h0000_300C);
    write_reg(5'd2, 32'd8);
    check32("beq_not_taken", 32'(NPC_ctrl), 32'd0);
    load_ins(32'h3010, mk_i(6'b000101, 5'd1, 5'd2, 16'h0003));
    check32("bne_taken_npc", 32'(NPC_ctrl), 32'd1);
    check32("bne_br",        BR, 32'h0000_301C);

    // Branch target wrap-around at the top of the address space.
    load_ins(32'hFFFF_FFFC, mk_i(6'b000100, 5'd1, 5'd1, 16'h0002));
    check32("br_wrap", BR, 32'h0000_0004);

    // Forwarded operands feed the compare.
    Fwd_RT_sel = 2'b01; Fwd_M = 32'd7;
    load_ins(32'h3010, mk_i(6'b000100, 5'd1, 5'd2, 16'h0001));
    check32("fwd_m_rd2",    RD2, 32'd7);
    check32("fwd_beq_npc",  32'(NPC_ctrl), 32'd1);
    Fwd_RT_sel = 2'b11;
    #1;
    check32("fwd_sel11_rd2", RD2, 32'd8);
    check32("fwd_sel11_npc", 32'(NPC_ctrl), 32'd0);
    Fwd_RT_sel = 2'b00; Fwd_M = 32'h0;

    // jal / j / jr.
    load_ins(32'h3008, {6'b000011, 26'h000_0C04});
    check32("jal_npc",   32'(NPC_ctrl), 32'd3);
    check32("jal_j_jal", J_JAL, 32'h0000_3010);
    load_ins(32'h9000_0000, {6'b000010, 26'h3FF_FFFF});
    check32("j_npc",   32'(NPC_ctrl), 32'd3);
    check32("j_j_jal", J_JAL, 32'h9FFF_FFFC);
    write_reg(5'd31, 32'h0000_5555);
    Fwd_RS_sel = 2'b10; Fwd_E = 32'h0000_3020;
    load_ins(32'h3030, {6'd0, 5'd31, 15'd0, 6'b001000});
    check32("jr_npc", 32'(NPC_ctrl), 32'd2);
    check32("jr_fwd_e", JR, 32'h0000_3020);
    Fwd_RS_sel = 2'b01; Fwd_M = 32'h0000_4040;
    #1;
    check32("jr_fwd_m", JR, 32'h0000_4040);
    Fwd_RS_sel = 2'b00;
    #1;
    check32("jr_rf", JR, 32'h0000_5555);
    Fwd_E = 32'h0; Fwd_M = 32'h0;

    // Stall: D holds for three cycles while fetch changes.
    load_ins(32'h3040, mk_i(6'b000100, 5'd1, 5'd1, 16'h0004));
    for (int i = 0; i < 3; i++) begin
      PC4_F = 32'h5000 + 32'(i * 4);
      Ins_F = mk_i(6'b000010, 5'(i), 5'(i), 16'(i));
      tick();
      check32("stall_ins_d", Ins_D, mk_i(6'b000100, 5'd1, 5'd1, 16'h0004));
      check32("stall_pc4_d", PC4_D, 32'h3040);
      check32("stall_npc",   32'(NPC_ctrl), 32'd1);
      check32("stall_br",    BR, 32'h3050);
    end
    load_ins(32'h3044, mk_add(5'd1, 5'd2));
    check32("resume_ins_d", Ins_D, mk_add(5'd1, 5'd2));
    check32("resume_pc4_d", PC4_D, 32'h3044);

    // Reset mid-operation with a taken beq in D.
    load_ins(32'h3050, mk_i(6'b000100, 5'd1, 5'd1, 16'h0010));
    check32("pre_rst_npc", 32'(NPC_ctrl), 32'd1);
    Reset = 1'b0;
    En = 1'b1; Ins_F = mk_i(6'b000100, 5'd1, 5'd1, 16'h0010);
    tick();
    Reset = 1'b1; En = 1'b0;
    #1;
    check32("mid_rst_ins_d", Ins_D, 32'h0);
    check32("mid_rst_pc4_d", PC4_D, 32'h0000_3004);
    check32("mid_rst_npc",   32'(NPC_ctrl), 32'd0);
    for (int i = 1; i < 32; i++) begin
      load_ins(32'h3008, mk_add(5'(i), 5'(i)));
      check32("mid_rst_reg", RD1, 32'h0);
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage of the 5-stage MIPS pipeline, directly downstream of the fetch unit.
- Holds the IF/ID pipeline register and the 32x32 general register file.
- Resolves beq/j/jal/jr in D with operand forwarding, and returns BR, JR, J_JAL and NPC_ctrl to the fetch unit.
- Delay-slot architecture: there is no flush; the slot instruction always proceeds.

Parameters:
- RESET_PC4, 32'h0000_3004, value loaded into PC4_D on reset.
- REG_NUM, 32, number of architectural registers (fixed at 32; the parameter is for documentation only).

Ports:
- Clk  in  1  system clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-low reset; takes effect at a rising edge of Clk while low.
- En  in  1  IF/ID load enable; 0 = stall (hold).
- PC4_F  in  32  PC+4 from fetch.
- Ins_F  in  32  instruction from fetch.
- RegWrite_W  in  1  writeback write enable.
- A3_W  in  5  writeback destination register.
- WD_W  in  32  writeback data.
- Fwd_RS_sel  in  2  rs source select: 00 = RF, 01 = Fwd_M, 10 = Fwd_E, 11 = RF.
- Fwd_RT_sel  in  2  rt source select, same encoding as Fwd_RS_sel.
- Fwd_E  in  32  forwarded value from the E stage.
- Fwd_M  in  32  forwarded value from the M stage.
- Ins_D  out  32  registered instruction.
- PC4_D  out  32  registered PC+4.
- RD1  out  32  forwarded rs value.
- RD2  out  32  forwarded rt value.
- BR  out  32  branch target.
- JR  out  32  jr target.
- J_JAL  out  32  j/jal target.
- NPC_ctrl  out  2  next-PC select: 00 = PC4, 01 = BR, 10 = JR, 11 = J_JAL.

Behaviour:

IF/ID register:
- Reset low at an edge: Ins_D <= 0 (nop) and PC4_D <= RESET_PC4. Reset has priority over En.
- Otherwise, if En = 1: Ins_D <= Ins_F and PC4_D <= PC4_F.
- Otherwise (En = 0): hold both values.

Register file:
- 32 registers of 32 bits. Reset low at an edge clears all registers to 0.
- Write: at an edge with Reset high, RegWrite_W = 1 and A3_W != 0, reg[A3_W] <= WD_W.
- Writes to $0 are ignored; $0 always reads 0.
- Reads are combinational from Ins_D[25:21] (rs) and Ins_D[20:16] (rt).
- Write-through bypass: if RegWrite_W = 1, A3_W != 0 and A3_W equals the read address, the read returns WD_W in the same cycle.

Forwarding:
- RD1 and RD2 are muxed by Fwd_RS_sel and Fwd_RT_sel. Select 11 behaves as 00.
- The compare and JR paths use the forwarded values, never the raw RF values.

Target computation (all combinational from Ins_D and PC4_D):
- BR = PC4_D + ({{14{Ins_D[15]}}, Ins_D[15:0], 2'b00}); 32-bit wrap-around, no overflow detection.
- J_JAL = {PC4_D[31:28], Ins_D[25:0], 2'b00}.
- JR = RD1.

NPC_ctrl decode, op = Ins_D[31:26], funct = Ins_D[5:0]:
- op 000100 (beq): 01 if RD1 == RD2, else 00.
- op 000101 (bne): 01 if RD1 != RD2, else 00.
- op 000010 (j) or 000011 (jal): 11.
- op 000000 with funct 001000 (jr): 10.
- Any other instruction, including nop: 00.

Stall behaviour:
- When En = 0, the outputs are still computed from the held Ins_D. The fetch unit is also stalled, so a repeated redirect is harmless.
- Targets and NPC_ctrl are therefore stable for the whole stall.

Reset mid-operation:
- The next edge with Reset low forces nop in D, giving NPC_ctrl = 00. The RF is cleared on that same edge.

Latency:
- Fetch-to-D: 1 cycle.
- W-write to D-read: 0 cycles (bypass).
- Branch decision: same cycle the instruction is in D.

Test Plan:
- Reset low for 2 cycles, then high -> Ins_D = 0, PC4_D = 32'h3004, NPC_ctrl = 00; reading $1..$31 gives 0.
- W writes $5 = 32'hDEAD_BEEF while D holds an instruction with rs = 5 in the same cycle -> RD1 = 32'hDEAD_BEEF immediately. A write to $0 of 32'h1234 -> $0 still reads 0.
- beq $1,$2,-1 (imm = 16'hFFFF) with PC4_D = 32'h3010 and $1 = $2 = 7 -> NPC_ctrl = 01, BR = 32'h300C. With $2 = 8 -> NPC_ctrl = 00.
- jal with index 26'h0000C04 and PC4_D = 32'h3008 -> NPC_ctrl = 11, J_JAL = 32'h3010. jr $31 with Fwd_RS_sel = 10 and Fwd_E = 32'h3020 -> NPC_ctrl = 10, JR = 32'h3020, ignoring the RF value of $31.
- En = 0 for 3 cycles while Ins_F changes -> Ins_D and PC4_D are held, and NPC_ctrl stays constant. En returns to 1 -> the next Ins_F is captured on that edge.
- Reset pulled low while a beq is in D with taken operands -> after that edge, Ins_D = 0, NPC_ctrl = 00, and all registers read 0.
